// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//
// Destination end of the MEM/WB pipeline register. It selects the writeback
// result, commits it to the architectural register file, and serves two
// combinational read ports to Decode. A per-register pending-write scoreboard
// lets Decode stall on a source whose producer has issued but not yet written
// back.
//
// Configuration macro:
//   WB_BYPASS_EN  defined   : a same-cycle writeback is forwarded to the read
//                             ports, and the pending flag for that register is
//                             masked in that cycle.
//                 undefined : reads return stored contents only, and pending
//                             flags are not masked.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   regWriteW, memToRegW     W-stage writeback enable and result select
//   readDataW, aluOutW       W-stage load data and ALU result
//   writeRegW                W-stage destination index
//   resultW                  selected writeback value (combinational)
//   readAddr1D/readAddr2D    Decode source indices
//   readData1D/readData2D    Decode source data (combinational)
//   issueValidD, issueRegD   instruction with a destination leaves Decode
//   pending1D/pending2D      source has an outstanding write
//
// Handshake note: issueValidD is a one-sided valid with no ready. Every cycle
// it is high, one issue is recorded. Decode must not issue to a register that
// is already pending, because only one producer per register is tracked.
// -----------------------------------------------------------------------------
module writeback_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWriteW,
  input  logic                  memToRegW,
  input  logic [DATA_WIDTH-1:0] readDataW,
  input  logic [DATA_WIDTH-1:0] aluOutW,
  input  logic [ADDR_WIDTH-1:0] writeRegW,
  output logic [DATA_WIDTH-1:0] resultW,
  input  logic [ADDR_WIDTH-1:0] readAddr1D,
  input  logic [ADDR_WIDTH-1:0] readAddr2D,
  output logic [DATA_WIDTH-1:0] readData1D,
  output logic [DATA_WIDTH-1:0] readData2D,
  input  logic                  issueValidD,
  input  logic [ADDR_WIDTH-1:0] issueRegD,
  output logic                  pending1D,
  output logic                  pending2D
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      pending_q;
  logic [DEPTH-1:0]      pending_d;

  // ---------------------------------------------------------------------------
  // Result mux and qualified write/issue strobes
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic issue_en;

  always_comb begin
    resultW  = memToRegW ? readDataW : aluOutW;
    // Index 0 is hard-wired to zero, so writes and issues to it are ignored.
    wr_en    = regWriteW && (writeRegW != '0);
    issue_en = issueValidD && (issueRegD != '0);
  end

  // ---------------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[writeRegW] = resultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    // The clear is applied first and the set second. When both hit the same
    // index, the set wins, because the newer producer is still outstanding.
    if (wr_en) begin
      pending_d[writeRegW] = 1'b0;
    end
    if (issue_en) begin
      pending_d[issueRegD] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // The storage is cleared asynchronously, so it already reads 0 under reset.
  // The extra rst qualification keeps the bypass path from leaking resultW
  // while reset is asserted.
`ifdef WB_BYPASS_EN
  logic wr_hit1;
  logic wr_hit2;

  always_comb begin
    wr_hit1 = wr_en && (writeRegW == readAddr1D);
    wr_hit2 = wr_en && (writeRegW == readAddr2D);
  end
`endif

  always_comb begin
    readData1D = '0;
    readData2D = '0;
    if (rst && (readAddr1D != '0)) begin
      readData1D = mem_q[readAddr1D];
    end
    if (rst && (readAddr2D != '0)) begin
      readData2D = mem_q[readAddr2D];
    end
`ifdef WB_BYPASS_EN
    // Write-through: the value being committed this cycle is visible now.
    if (rst && wr_hit1) begin
      readData1D = resultW;
    end
    if (rst && wr_hit2) begin
      readData2D = resultW;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Pending outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pending1D = rst && pending_q[readAddr1D];
    pending2D = rst && pending_q[readAddr2D];
`ifdef WB_BYPASS_EN
    // The value arrives through the bypass this cycle, so Decode need not stall.
    if (wr_hit1) begin
      pending1D = 1'b0;
    end
    if (wr_hit2) begin
      pending2D = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// -----------------------------------------------------------------------------
// tb_writeback_regfile
//
// Directed bench for writeback_regfile. Each scenario task drives its own
// stimulus and checks its results inline against hand-computed values.
// -----------------------------------------------------------------------------
module tb_writeback_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          regWriteW;
  logic          memToRegW;
  logic [DW-1:0] readDataW;
  logic [DW-1:0] aluOutW;
  logic [AW-1:0] writeRegW;
  logic [DW-1:0] resultW;
  logic [AW-1:0] readAddr1D;
  logic [AW-1:0] readAddr2D;
  logic [DW-1:0] readData1D;
  logic [DW-1:0] readData2D;
  logic          issueValidD;
  logic [AW-1:0] issueRegD;
  logic          pending1D;
  logic          pending2D;

  int n_cmp;
  int n_bad;

  writeback_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .regWriteW   (regWriteW),
    .memToRegW   (memToRegW),
    .readDataW   (readDataW),
    .aluOutW     (aluOutW),
    .writeRegW   (writeRegW),
    .resultW     (resultW),
    .readAddr1D  (readAddr1D),
    .readAddr2D  (readAddr2D),
    .readData1D  (readData1D),
    .readData2D  (readData2D),
    .issueValidD (issueValidD),
    .issueRegD   (issueRegD),
    .pending1D   (pending1D),
    .pending2D   (pending2D)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Inputs change and outputs are sampled 1 time unit
  // after the edge, well away from the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    regWriteW   = 1'b0;
    memToRegW   = 1'b0;
    readDataW   = '0;
    aluOutW     = '0;
    writeRegW   = '0;
    issueValidD = 1'b0;
    issueRegD   = '0;
  endtask

  task automatic drive_write(input logic [AW-1:0] idx, input logic [DW-1:0] val);
    regWriteW = 1'b1;
    memToRegW = 1'b0;
    aluOutW   = val;
    writeRegW = idx;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst        = 1'b0;
    readAddr1D = 5'd5;
    readAddr2D = 5'd31;
    step();
    step();
    n_cmp++;
    if (readData1D !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd1: got %h exp %h", readData1D, 32'h0);
    end
    n_cmp++;
    if (readData2D !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd2: got %h exp %h", readData2D, 32'h0);
    end
    n_cmp++;
    if ({pending1D, pending2D} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_pend: got %b%b exp 00", pending1D, pending2D);
    end
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({readData1D, readData2D} !== 64'h0) begin
      n_bad++;
      $display("FAIL post_reset_rd: got %h/%h exp 0/0", readData1D, readData2D);
    end
  endtask

  task automatic test_write_read();
    drive_write(5'd7, 32'h1234_5678);
    #1;
    n_cmp++;
    if (resultW !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL result_alu: got %h exp %h", resultW, 32'h1234_5678);
    end
    step();
    idle_inputs();
    readAddr1D = 5'd7;
    #1;
    n_cmp++;
    if (readData1D !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL wr_alu_rd: got %h exp %h", readData1D, 32'h1234_5678);
    end
    // Load data path: memToRegW selects readDataW over aluOutW.
    regWriteW = 1'b1;
    memToRegW = 1'b1;
    readDataW = 32'hDEAD_BEEF;
    aluOutW   = 32'h0BAD_F00D;
    writeRegW = 5'd8;
    #1;
    n_cmp++;
    if (resultW !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL result_mem: got %h exp %h", resultW, 32'hDEAD_BEEF);
    end
    step();
    idle_inputs();
    readAddr1D = 5'd8;
    readAddr2D = 5'd8;
    #1;
    n_cmp++;
    if (readData1D !== 32'hDEAD_BEEF || readData2D !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL wr_mem_rd_both: got %h/%h exp %h", readData1D, readData2D, 32'hDEAD_BEEF);
    end
    // With regWriteW low, nothing may commit.
    aluOutW   = 32'hCAFE_CAFE;
    writeRegW = 5'd7;
    step();
    readAddr1D = 5'd7;
    #1;
    n_cmp++;
    if (readData1D !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL no_write_en: got %h exp %h", readData1D, 32'h1234_5678);
    end
  endtask

  task automatic test_reg_zero();
    drive_write(5'd0, 32'hFFFF_FFFF);
    issueValidD = 1'b1;
    issueRegD   = 5'd0;
    step();
    idle_inputs();
    readAddr1D = 5'd0;
    readAddr2D = 5'd0;
    #1;
    n_cmp++;
    if (readData1D !== 32'h0 || readData2D !== 32'h0) begin
      n_bad++;
      $display("FAIL reg0_read: got %h/%h exp 0/0", readData1D, readData2D);
    end
    n_cmp++;
    if ({pending1D, pending2D} !== 2'b00) begin
      n_bad++;
      $display("FAIL reg0_pend: got %b%b exp 00", pending1D, pending2D);
    end
  endtask

  task automatic test_bypass();
    drive_write(5'd3, 32'h11);
    step();
    idle_inputs();
    issueValidD = 1'b1;
    issueRegD   = 5'd3;
    step();
    idle_inputs();
    drive_write(5'd3, 32'h22);
    readAddr1D = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    n_cmp++;
    if (readData1D !== 32'h22) begin
      n_bad++;
      $display("FAIL bypass_data: got %h exp %h", readData1D, 32'h22);
    end
    n_cmp++;
    if (pending1D !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_pend_mask: got %b exp 0", pending1D);
    end
`else
    n_cmp++;
    if (readData1D !== 32'h11) begin
      n_bad++;
      $display("FAIL nobypass_data: got %h exp %h", readData1D, 32'h11);
    end
    n_cmp++;
    if (pending1D !== 1'b1) begin
      n_bad++;
      $display("FAIL nobypass_pend: got %b exp 1", pending1D);
    end
`endif
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (readData1D !== 32'h22 || pending1D !== 1'b0) begin
      n_bad++;
      $display("FAIL bypass_next: got %h pend %b exp %h pend 0", readData1D, pending1D, 32'h22);
    end
  endtask

  task automatic test_scoreboard();
    readAddr1D  = 5'd9;
    readAddr2D  = 5'd10;
    issueValidD = 1'b1;
    issueRegD   = 5'd9;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (pending1D !== 1'b1) begin
        n_bad++;
        $display("FAIL sb_held cyc%0d: got %b exp 1", i, pending1D);
      end
      step();
    end
    drive_write(5'd9, 32'h99);
    #1;
`ifdef WB_BYPASS_EN
    n_cmp++;
    if (pending1D !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_wb_cycle: got %b exp 0", pending1D);
    end
`else
    n_cmp++;
    if (pending1D !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_wb_cycle: got %b exp 1", pending1D);
    end
`endif
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (pending1D !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_cleared: got %b exp 0", pending1D);
    end
    // Issue and writeback to the same index in one cycle: the set wins.
    issueValidD = 1'b1;
    issueRegD   = 5'd9;
    step();
    drive_write(5'd9, 32'h98);
    issueValidD = 1'b1;
    issueRegD   = 5'd9;
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (pending1D !== 1'b1) begin
      n_bad++;
      $display("FAIL sb_set_wins: got %b exp 1", pending1D);
    end
    // Different indices: the clear on 9 and the set on 10 both land.
    drive_write(5'd9, 32'h97);
    issueValidD = 1'b1;
    issueRegD   = 5'd10;
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if ({pending1D, pending2D} !== 2'b01) begin
      n_bad++;
      $display("FAIL sb_diff_idx: got %b%b exp 01", pending1D, pending2D);
    end
    // Clear reg 10 so later scenarios start with a clean scoreboard.
    drive_write(5'd10, 32'hA0);
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    drive_write(5'd4, 32'h44);
    step();
    idle_inputs();
    issueValidD = 1'b1;
    issueRegD   = 5'd4;
    step();
    idle_inputs();
    readAddr1D = 5'd4;
    readAddr2D = 5'd7;
    #1;
    n_cmp++;
    if (pending1D !== 1'b1 || readData1D !== 32'h44) begin
      n_bad++;
      $display("FAIL mid_pre: got %h pend %b exp %h pend 1", readData1D, pending1D, 32'h44);
    end
    drive_write(5'd4, 32'h55);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pending1D !== 1'b0 || readData1D !== 32'h0 || readData2D !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_rst_now: got %h/%h pend %b exp 0/0 pend 0", readData1D, readData2D, pending1D);
    end
    n_cmp++;
    if (resultW !== 32'h55) begin
      n_bad++;
      $display("FAIL mid_rst_result: got %h exp %h", resultW, 32'h55);
    end
    step();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (readData1D !== 32'h0 || pending1D !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_no_commit: got %h pend %b exp 0 pend 0", readData1D, pending1D);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    readAddr1D = '0;
    readAddr2D = '0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_reg_zero();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Destination end of the MEM/WB pipeline register: consumes the W-stage control and data, selects the writeback result and commits it to the 32-entry architectural register file.
- Supplies two combinational read ports to the Decode stage.
- Keeps a per-register pending-write scoreboard so Decode can stall on a source whose producer has issued but not yet written back.

Parameters:
- DATA_WIDTH, 32, register/data width in bits
- ADDR_WIDTH, 5, register index width; file depth = 2**ADDR_WIDTH

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- regWriteW  input  1  writeback enable from MEM/WB register
- memToRegW  input  1  1 = write readDataW, 0 = write aluOutW
- readDataW  input  DATA_WIDTH  load data from MEM/WB register
- aluOutW  input  DATA_WIDTH  ALU result from MEM/WB register
- writeRegW  input  ADDR_WIDTH  destination register index
- resultW  output  DATA_WIDTH  selected writeback value, combinational; also feeds the forwarding muxes
- readAddr1D  input  ADDR_WIDTH  Decode source A index
- readAddr2D  input  ADDR_WIDTH  Decode source B index
- readData1D  output  DATA_WIDTH  source A data, combinational
- readData2D  output  DATA_WIDTH  source B data, combinational
- issueValidD  input  1  instruction with a register destination leaves Decode this cycle
- issueRegD  input  ADDR_WIDTH  destination index of the issuing instruction
- pending1D  output  1  source A has an outstanding write
- pending2D  output  1  source B has an outstanding write

Behaviour:
- Reset: rst low asynchronously clears all registers to 0 and all pending bits to 0.
  - All outputs are then combinationally 0, except resultW, which follows its mux.
  - Asserting reset mid-operation discards in-flight writes and pending state immediately.
- Result mux: resultW = memToRegW ? readDataW : aluOutW. It is pure combinational and independent of regWriteW.
- Write:
  - Commits at posedge clk when regWriteW=1 and writeRegW!=0; mem[writeRegW] <= resultW. Latency is 1 cycle.
  - Writes to index 0 are dropped. Register 0 always reads 0.
- Read:
  - readDataN = 0 if readAddrN==0, else mem[readAddrN]. This is subject to the bypass described under Optional Feature.
  - Both ports may address the same register; both return identical data.
- Scoreboard: one pending bit per register, bit 0 tied to 0.
  - Set at posedge when issueValidD=1 and issueRegD!=0.
  - Cleared at posedge when regWriteW=1 and writeRegW!=0.
  - If set and clear target the same index in the same cycle, set wins: the newer producer is still outstanding.
  - Set and clear on different indices both take effect.
- Pending outputs:
  - pendingND = pending[readAddrN].
  - pendingND is masked to 0 when regWriteW=1 and writeRegW==readAddrN, because the value is available this cycle via bypass. Under the disabled-bypass build this mask is removed.
- Only one outstanding producer per register is tracked.
  - Decode must stall rather than issue to a pending destination.
  - A second issue to an already-pending register leaves the bit set. Its first writeback clears the bit; this is documented behaviour, not an error.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - Write-through bypass: if regWriteW=1, writeRegW!=0 and writeRegW==readAddrN, then readDataND = resultW in the same cycle.
  - pendingND is masked as described under Behaviour.
- Undefined:
  - Reads return stored contents only; a same-cycle write is visible the next cycle.
  - pendingND is not masked, so Decode stalls one extra cycle on the writeback cycle.

Test Plan:
- Reset: hold rst=0, read addr 5 and 31 -> readData 0, pending 0. Release rst; values stay 0 until a write.
- Write/read: regWriteW=1, memToRegW=0, aluOutW=0x1234_5678, writeRegW=7. After the edge, readAddr1D=7 -> 0x1234_5678. Repeat with memToRegW=1, readDataW=0xDEAD_BEEF -> 0xDEAD_BEEF.
- Register zero: write 0xFFFF_FFFF to index 0 -> readAddr1D=0 and readAddr2D=0 both return 0; issueRegD=0 never sets pending.
- Bypass: mem[3]=0x11. In the same cycle, write 0x22 to 3 and read 3:
  - WB_BYPASS_EN defined -> 0x22 now, pending1D=0.
  - Undefined -> 0x11 now, 0x22 next cycle.
- Scoreboard: issue reg 9, then readAddr1D=9 -> pending1D=1 for 3 cycles. Writeback to 9 clears it. Simultaneous issue 9 plus writeback 9 -> pending stays 1.
- Reset mid-operation: with pending[4]=1 and regWriteW=1, pull rst low between edges -> pending1D (addr 4)=0 and mem[4]=0 immediately; no write commits.
